// File: rtl/bp_be_fe_cmd_issue_pkg.sv
// Shared FE command types for the BE->FE command issuer: opcode enum, command
// struct and the derived command width.
package bp_be_fe_cmd_issue_pkg;

    localparam int vaddr_width_p = 39;

    typedef enum logic [2:0] {
        e_op_state_reset          = 3'd0,
        e_op_pc_redirection       = 3'd1,
        e_op_icache_fill_response = 3'd2,
        e_op_icache_fence         = 3'd3,
        e_op_itlb_fill_response   = 3'd4,
        e_op_attaboy              = 3'd5
    } bp_fe_command_queue_opcodes_e;

    typedef struct packed {
        bp_fe_command_queue_opcodes_e opcode;
        logic [vaddr_width_p-1:0]     npc;
        logic [1:0]                   priv;
        logic                         translation_en;
    } bp_fe_cmd_s;

    localparam int fe_cmd_width_lp = $bits(bp_fe_cmd_s);

    // Commands that invalidate whatever FE has already pushed into fe_queue
    function automatic logic is_flush_op(input bp_fe_command_queue_opcodes_e op);
        return (op == e_op_pc_redirection) || (op == e_op_state_reset);
    endfunction

endpackage

// File: rtl/bp_be_fe_cmd_issue_if.sv
// Command channel bundle: BE command producer, attaboy hints and the FE-facing
// valid/yumi port. master = the issuer, slave = its environment.
interface bp_be_fe_cmd_issue_if;
    import bp_be_fe_cmd_issue_pkg::*;

    bp_fe_cmd_s cmd;
    logic       cmd_v;
    logic       cmd_ready_and;
    bp_fe_cmd_s attaboy;
    logic       attaboy_v;
    bp_fe_cmd_s fe_cmd;
    logic       fe_cmd_v;
    logic       fe_cmd_yumi;

    modport master (
        input  cmd, cmd_v, attaboy, attaboy_v, fe_cmd_yumi,
        output cmd_ready_and, fe_cmd, fe_cmd_v
    );

    modport slave (
        output cmd, cmd_v, attaboy, attaboy_v, fe_cmd_yumi,
        input  cmd_ready_and, fe_cmd, fe_cmd_v
    );

endinterface

// File: rtl/bp_be_fe_cmd_issue_fifo.sv
// Small 1R1W FIFO with registered occupancy; head is read from the array at
// the registered read pointer, ready depends only on the registered count.
module bp_be_fe_cmd_issue_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp-1:0] rptr_reg, wptr_reg;
    logic [cnt_w_lp-1:0] cnt_reg;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (cnt_reg != cnt_w_lp'(els_p));
    assign v_o     = (cnt_reg != '0);
    assign data_o  = mem[rptr_reg];

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem[wptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rptr_reg <= '0;
            wptr_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            if (v_i)    wptr_reg <= ptr_inc(wptr_reg);
            if (yumi_i) rptr_reg <= ptr_inc(rptr_reg);
            cnt_reg <= cnt_reg + cnt_w_lp'(v_i) - cnt_w_lp'(yumi_i);
        end
    end

endmodule

// File: rtl/bp_be_fe_cmd_issue.sv
// BE-side FE command issuer: boots FE with a state_reset command, then issues
// ordered BE commands ahead of a single best-effort attaboy slot.
module bp_be_fe_cmd_issue
    import bp_be_fe_cmd_issue_pkg::*;
#(
    parameter int cmd_fifo_els_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [vaddr_width_p-1:0] cfg_npc_i,
    input  logic [1:0]               cfg_priv_i,
    bp_be_fe_cmd_issue_if.master     io,
    output logic                     fe_queue_ready_and_o,
    output logic                     fe_queue_clr_o,
    output logic                     busy_o,
    output logic                     attaboy_drop_o
);
    localparam logic [1:0] e_boot = 2'd0;
    localparam logic [1:0] e_init = 2'd1;
    localparam logic [1:0] e_run  = 2'd2;
    localparam int cnt_w_lp = $clog2(cmd_fifo_els_p + 2);

    logic [1:0]          state_reg, state_next;
    logic [cnt_w_lp-1:0] count_reg, count_next;
    logic                slot_v_reg, slot_v_next;
    bp_fe_cmd_s          boot_cmd_reg, slot_reg, fifo_data;
    logic                fifo_v, fifo_ready, fifo_yumi;
    logic                in_run, enq, slot_deq, init_yumi, clr_slot;

    bp_be_fe_cmd_issue_fifo #(
        .els_p   (cmd_fifo_els_p),
        .width_p (fe_cmd_width_lp)
    ) cmd_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (io.cmd),
        .v_i       (enq),
        .ready_o   (fifo_ready),
        .data_o    (fifo_data),
        .v_o       (fifo_v),
        .yumi_i    (fifo_yumi)
    );

    // Outputs are qualified by reset so nothing leaks out while reset is held
    assign in_run           = reset_n_i & (state_reg == e_run);
    assign io.cmd_ready_and = in_run & fifo_ready;
    assign enq              = io.cmd_v & io.cmd_ready_and;
    assign io.fe_cmd_v      = reset_n_i & ((state_reg == e_init)
                                         | ((state_reg == e_run) & (fifo_v | slot_v_reg)));
    assign io.fe_cmd        = (state_reg != e_run) ? boot_cmd_reg
                            : (fifo_v ? fifo_data : slot_reg);
    assign fifo_yumi        = in_run & fifo_v & io.fe_cmd_yumi;
    assign slot_deq         = in_run & ~fifo_v & slot_v_reg & io.fe_cmd_yumi;
    assign init_yumi        = reset_n_i & (state_reg == e_init) & io.fe_cmd_yumi;
    assign clr_slot         = enq & (io.cmd.opcode == e_op_state_reset);

    assign fe_queue_clr_o       = (enq & is_flush_op(io.cmd.opcode)) | init_yumi;
    assign fe_queue_ready_and_o = in_run & (count_reg == '0);
    assign busy_o               = ~in_run | (count_reg != '0);
    assign attaboy_drop_o       = reset_n_i & (clr_slot
                                ? ((slot_v_reg & ~slot_deq) | io.attaboy_v)
                                : (io.attaboy_v & slot_v_reg & ~slot_deq));

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg + cnt_w_lp'(enq) - cnt_w_lp'(fifo_yumi | init_yumi);
        slot_v_next = slot_v_reg;
        case (state_reg)
            e_boot: begin
                state_next = e_init;
                count_next = cnt_w_lp'(1);
            end
            e_init:  if (io.fe_cmd_yumi) state_next = e_run;
            default: state_next = e_run;
        endcase
        if (clr_slot)          slot_v_next = 1'b0;
        else if (io.attaboy_v) slot_v_next = 1'b1;
        else if (slot_deq)     slot_v_next = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg  <= e_boot;
            count_reg  <= '0;
            slot_v_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            slot_v_reg <= slot_v_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_reg == e_boot) begin
            boot_cmd_reg <= '{opcode: e_op_state_reset, npc: cfg_npc_i,
                              priv: cfg_priv_i, translation_en: 1'b0};
        end
        if (io.attaboy_v) begin
            slot_reg <= io.attaboy;
        end
    end

    // FE must never consume a command that is not being offered
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(io.fe_cmd_yumi && !io.fe_cmd_v));
        end
    end

endmodule

// File: tb/tb_bp_be_fe_cmd_issue.sv
// Randomized bench for bp_be_fe_cmd_issue against a queue-based model of the
// boot / ordered-command / attaboy-hint rules.
module tb_bp_be_fe_cmd_issue;
    import bp_be_fe_cmd_issue_pkg::*;

    localparam int ELS = 4;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [vaddr_width_p-1:0] cfg_npc = 39'h8000_0000;
    logic [1:0]               cfg_priv = 2'b11;
    logic                     fq_ready, fq_clr, busy, drop;

    bp_be_fe_cmd_issue_if io();

    bp_be_fe_cmd_issue #(.cmd_fifo_els_p(ELS)) dut (
        .clk_i                (clk),
        .reset_n_i            (reset_n),
        .cfg_npc_i            (cfg_npc),
        .cfg_priv_i           (cfg_priv),
        .io                   (io),
        .fe_queue_ready_and_o (fq_ready),
        .fe_queue_clr_o       (fq_clr),
        .busy_o               (busy),
        .attaboy_drop_o       (drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 = waiting to boot, 1 = boot command offered, 2 = running
    int         phase = 0;
    bp_fe_cmd_s exp_q[$];
    logic       m_slot_v = 1'b0;
    bp_fe_cmd_s m_slot = '0;
    bp_fe_cmd_s m_boot = '0;
    bp_fe_cmd_s nul = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bp_fe_cmd_s mk(input bp_fe_command_queue_opcodes_e op,
                                      input logic [vaddr_width_p-1:0] npc);
        bp_fe_cmd_s c;
        c = '0;
        c.opcode = op;
        c.npc = npc;
        c.priv = 2'b11;
        c.translation_en = 1'b1;
        return c;
    endfunction

    function automatic logic model_v();
        return (phase == 1) || (phase == 2 && (exp_q.size() != 0 || m_slot_v));
    endfunction

    // One clock: apply inputs after negedge, check outputs, advance model at posedge
    task automatic cycle(input logic rst, input logic cv, input bp_fe_cmd_s c,
                         input logic av, input bp_fe_cmd_s a, input logic want_y);
        logic y, e_v, e_rdy, e_fqr, e_clr, e_busy, e_drop, enq, sdeq, rst_enq;
        bp_fe_cmd_s e_cmd;
        y = rst & want_y & model_v();
        reset_n = rst;
        io.cmd = c;
        io.cmd_v = cv;
        io.attaboy = a;
        io.attaboy_v = av;
        io.fe_cmd_yumi = y;

        e_v = rst & model_v();
        if (phase != 2)             e_cmd = m_boot;
        else if (exp_q.size() != 0) e_cmd = exp_q[0];
        else                        e_cmd = m_slot;
        e_rdy   = rst && phase == 2 && exp_q.size() < ELS;
        enq     = cv && e_rdy;
        sdeq    = rst && phase == 2 && exp_q.size() == 0 && m_slot_v && y;
        rst_enq = enq && c.opcode == e_op_state_reset;
        e_clr   = (enq && (c.opcode == e_op_pc_redirection || c.opcode == e_op_state_reset))
                  || (rst && phase == 1 && y);
        e_fqr   = rst && phase == 2 && exp_q.size() == 0;
        e_busy  = !rst || phase != 2 || exp_q.size() != 0;
        e_drop  = rst && (rst_enq ? ((m_slot_v && !sdeq) || av) : (av && m_slot_v && !sdeq));

        #2;
        check("fe_cmd_v", 64'(io.fe_cmd_v), 64'(e_v));
        if (e_v) check("fe_cmd", 64'(io.fe_cmd), 64'(e_cmd));
        check("cmd_ready", 64'(io.cmd_ready_and), 64'(e_rdy));
        check("fq_ready", 64'(fq_ready), 64'(e_fqr));
        check("fq_clr", 64'(fq_clr), 64'(e_clr));
        check("busy", 64'(busy), 64'(e_busy));
        check("attaboy_drop", 64'(drop), 64'(e_drop));

        @(posedge clk);
        if (!rst) begin
            phase = 0;
            exp_q.delete();
            m_slot_v = 1'b0;
        end else begin
            case (phase)
                0: begin
                    m_boot = '0;
                    m_boot.opcode = e_op_state_reset;
                    m_boot.npc = cfg_npc;
                    m_boot.priv = cfg_priv;
                    phase = 1;
                end
                1: if (y) phase = 2;
                default: begin
                    if (y && exp_q.size() != 0) void'(exp_q.pop_front());
                    if (enq) exp_q.push_back(c);
                end
            endcase
            if (rst_enq)   m_slot_v = 1'b0;
            else if (av)   begin m_slot_v = 1'b1; m_slot = a; end
            else if (sdeq) m_slot_v = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic y);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, nul, 1'b0, nul, y);
    endtask

    initial begin
        io.cmd = '0; io.cmd_v = 1'b0; io.attaboy = '0; io.attaboy_v = 1'b0; io.fe_cmd_yumi = 1'b0;
        @(negedge clk);

        // Boot: hold reset, release, FE consumes the state_reset after 3 cycles
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, nul, 1'b0, nul, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Fill FIFO with 4 redirects while FE stalls; 5th is refused
        for (int k = 1; k <= 4; k++)
            cycle(1'b1, 1'b1, mk(e_op_pc_redirection, 39'(k * 256)), 1'b0, nul, 1'b0);
        cycle(1'b1, 1'b1, mk(e_op_pc_redirection, 39'h500), 1'b0, nul, 1'b0);
        // Two back-to-back attaboys: first is overwritten
        cycle(1'b1, 1'b0, nul, 1'b1, mk(e_op_attaboy, 39'h10), 1'b0);
        cycle(1'b1, 1'b0, nul, 1'b1, mk(e_op_attaboy, 39'h20), 1'b0);
        idle(6, 1'b1);

        // Same-cycle enqueue and head yumi with one outstanding
        cycle(1'b1, 1'b1, mk(e_op_icache_fence, 39'h40), 1'b0, nul, 1'b0);
        cycle(1'b1, 1'b1, mk(e_op_icache_fill_response, 39'h80), 1'b0, nul, 1'b1);
        idle(2, 1'b1);

        // state_reset enqueue discards a pending attaboy
        cycle(1'b1, 1'b1, mk(e_op_icache_fence, 39'h44), 1'b1, mk(e_op_attaboy, 39'h30), 1'b0);
        cycle(1'b1, 1'b1, mk(e_op_state_reset, 39'h1000), 1'b0, nul, 1'b0);
        idle(4, 1'b1);

        // Reset mid-operation with two commands queued
        cycle(1'b1, 1'b1, mk(e_op_pc_redirection, 39'h600), 1'b0, nul, 1'b0);
        cycle(1'b1, 1'b1, mk(e_op_pc_redirection, 39'h700), 1'b0, nul, 1'b0);
        cfg_npc = 39'h4000;
        cycle(1'b0, 1'b0, nul, 1'b0, nul, 1'b0);
        cycle(1'b0, 1'b0, nul, 1'b0, nul, 1'b0);
        idle(4, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            logic rst, cv, av, y;
            logic [63:0] r1, r2;
            bp_fe_command_queue_opcodes_e op;
            rst = ($urandom_range(0, 199) != 0);
            if (!rst) begin
                r1 = {$urandom(), $urandom()};
                cfg_npc = 39'(r1);
                cfg_priv = 2'($urandom());
            end
            case ($urandom_range(0, 9))
                0:       op = e_op_state_reset;
                1, 2, 3: op = e_op_pc_redirection;
                4, 5:    op = e_op_icache_fill_response;
                6:       op = e_op_icache_fence;
                default: op = e_op_itlb_fill_response;
            endcase
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            cv = ($urandom_range(0, 2) == 0);
            av = ($urandom_range(0, 3) == 0);
            y  = ($urandom_range(0, 1) == 1);
            cycle(rst, cv, mk(op, 39'(r1)), av, mk(e_op_attaboy, 39'(r2)), y);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
